// File: rtl/sync_ram_arb_pkg.sv
// ============================================================================
// Module      : sync_ram_arb_pkg
// Description : Shared constants and helpers for the two-requester RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_ram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
    return (id == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker; i_last_gnt holds the id of the
//               previous winner, which loses a tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import sync_ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    case (i_req_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = id_to_onehot(~i_last_gnt);
      default: o_gnt = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sync_ram_arbiter.sv
// ============================================================================
// Module      : sync_ram_arbiter
// Description : Round-robin arbiter/sequencer for two masters sharing one
//               single-port synchronous RAM. Optional grant counters are
//               enabled by defining SYNC_RAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ram_arbiter
  import sync_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata
`ifdef SYNC_RAM_ARB_STATS_EN
  ,
  output logic [15:0]                 gnt_cnt0,
  output logic [15:0]                 gnt_cnt1
`endif
);

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_accept;
  logic               w_win;
  logic               r_last_gnt;

  logic               r_ram_we;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;

  // Completion tracking: stage 1 lines up with the RAM command cycle,
  // the response register lines up with the RAM read data.
  logic               r_s1_valid;
  logic               r_s1_id;
  logic [NUM_REQ-1:0] r_rsp_valid;

  rr_arb2 u_rr_arb2 (
    .i_req_valid (req_valid),
    .i_last_gnt  (r_last_gnt),
    .o_gnt       (w_gnt)
  );

  assign w_accept  = |w_gnt;
  assign w_win     = w_gnt[1];
  assign req_ready = w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt  <= REQ1;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= REQ0;
      r_rsp_valid <= '0;
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_id     <= w_win;
      r_rsp_valid <= r_s1_valid ? id_to_onehot(r_s1_id) : '0;
      if (w_accept) begin
        r_last_gnt  <= w_win;
        r_ram_we    <= req_we[w_win];
        r_ram_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
        r_ram_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
      end else begin
        r_ram_we    <= 1'b0;
      end
    end
  end

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = ram_rdata;

`ifdef SYNC_RAM_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_gnt[0]) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      if (w_gnt[1]) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_ram_arbiter.sv
// ============================================================================
// Module      : tb_sync_ram_arbiter
// Description : Directed scoreboard bench for sync_ram_arbiter with a
//               behavioural read-first synchronous RAM behind it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
`ifdef SYNC_RAM_ARB_STATS_EN
  logic [15:0]     gnt_cnt0;
  logic [15:0]     gnt_cnt1;
`endif

  sync_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef SYNC_RAM_ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  // Read-first single-port RAM with one cycle of read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int vectors    = 0;
  int miscompares = 0;

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sb.size() != 0 && cyc > sb[0].cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_rsp: id %0d due cycle %0d, still outstanding at cycle %0d",
               sb[0].id, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (rsp_valid !== 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid=%b at cycle %0d, required none", rsp_valid, cyc);
      end else begin
        exp_t e;
        logic [1:0] exp_v;
        e = sb.pop_front();
        exp_v = (e.id == 1) ? 2'b10 : 2'b01;
        if (rsp_valid !== exp_v || cyc != e.cyc || (e.rd && rsp_rdata !== e.data)) begin
          miscompares++;
          $display("FAIL rsp: got valid=%b cyc=%0d rdata=%h, required valid=%b cyc=%0d rdata=%h(rd=%0d)",
                   rsp_valid, cyc, rsp_rdata, exp_v, e.cyc, e.data, e.rd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // One request cycle; the expected winner is given by hand.
  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] exp_rdy, input logic [31:0] exp_rd,
                       input bit push);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (push && exp_rdy != 2'b00) begin
      exp_t e;
      e.id   = exp_rdy[1] ? 1 : 0;
      e.rd   = !we[e.id];
      e.data = exp_rd;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // 1. Reset values, and ready still follows req_valid while in reset.
    @(negedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_ram_we", 64'(ram_we), 64'h0);
    check("rst_ram_addr", 64'(ram_addr), 64'h0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'h0);
    check("rst_ready_idle", 64'(req_ready), 64'h0);
    req_valid = 2'b11;
    #1;
    check("rst_ready_both", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // 2. Requester 0 write then read of 0x0A.
    drive(2'b01, 2'b01, 8'h0A, 8'h00, 32'h12345678, 32'h0, 2'b01, 32'h0, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ram_we_wr", 64'(ram_we), 64'h1);
    check("ram_addr_wr", 64'(ram_addr), 64'h0A);
    check("ram_wdata_wr", 64'(ram_wdata), 64'h12345678);
    drive(2'b01, 2'b00, 8'h0A, 8'h00, 32'h0, 32'h0, 2'b01, 32'h12345678, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ram_we_rd", 64'(ram_we), 64'h0);
    @(negedge clk);
    #1;
    check("ram_we_idle", 64'(ram_we), 64'h0);
    check("ram_addr_hold", 64'(ram_addr), 64'h0A);
    idle_cycles(3);

    // 4. Requester 1 writes 0x14, requester 0 reads it the very next cycle.
    drive(2'b10, 2'b10, 8'h00, 8'h14, 32'h0, 32'hAABBCCDD, 2'b10, 32'h0, 1'b1);
    drive(2'b01, 2'b00, 8'h14, 8'h00, 32'h0, 32'h0, 2'b01, 32'hAABBCCDD, 1'b1);
    idle_cycles(4);

    // 3. Fresh reset so the tie starts with requester 0, then alternate.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 8'h14, 8'h14, 32'h0, 32'h0,
            (i % 2 == 0) ? 2'b01 : 2'b10, 32'hAABBCCDD, 1'b1);
    end
    idle_cycles(4);

    // 5. Reset one cycle after an accept drops the in-flight access.
    drive(2'b01, 2'b01, 8'h30, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01, 32'h0, 1'b0);
    @(negedge clk);
    idle_inputs();
    check("ram_we_pre_rst", 64'(ram_we), 64'h1);
    rst_n = 1'b0;
    #1;
    check("ram_we_in_rst", 64'(ram_we), 64'h0);
    check("rsp_in_rst", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);

`ifdef SYNC_RAM_ARB_STATS_EN
    // 6. Counter wrap: 70000 accepts of requester 0.
    apply_reset();
    for (int i = 0; i < 70000; i++) begin
      drive(2'b01, 2'b01, 8'h40, 8'h00, 32'(i), 32'h0, 2'b01, 32'h0, 1'b1);
    end
    idle_cycles(4);
    check("gnt_cnt0", 64'(gnt_cnt0), 64'd4464);
    check("gnt_cnt1", 64'(gnt_cnt1), 64'd0);
`endif

    idle_cycles(3);
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
